// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control path.
package arm_ctrl_pkg;

  localparam int unsigned ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/arm_mc_outdec.sv
// Combinational state -> control-word decoder; FETCH write requests are raw and
// still need mem_ready/reset gating by the caller.
module arm_mc_outdec
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic [STATE_W-1:0] i_state,
  output logic               o_irwrite,
  output logic               o_adrsrc,
  output logic               o_alusrca,
  output logic [1:0]         o_alusrcb,
  output logic [1:0]         o_resultsrc,
  output logic               o_aluop,
  output logic               o_nextpc,
  output logic               o_regw,
  output logic               o_memw,
  output logic               o_branch,
  output logic               o_illegal
);

  always_comb begin
    o_irwrite   = 1'b0;
    o_adrsrc    = 1'b0;
    o_alusrca   = 1'b0;
    o_alusrcb   = SRCB_REG;
    o_resultsrc = RES_ALUOUT;
    o_aluop     = 1'b0;
    o_nextpc    = 1'b0;
    o_regw      = 1'b0;
    o_memw      = 1'b0;
    o_branch    = 1'b0;
    o_illegal   = 1'b0;
    case (statetype_t'(i_state))
      FETCH: begin
        o_irwrite   = 1'b1;
        o_alusrca   = 1'b1;
        o_alusrcb   = SRCB_4;
        o_resultsrc = RES_ALU;
        o_nextpc    = 1'b1;
      end
      DECODE: begin
        o_alusrca   = 1'b1;
        o_alusrcb   = SRCB_4;
        o_resultsrc = RES_ALU;
      end
      MEMADR:   o_alusrcb = SRCB_IMM;
      MEMRD:    o_adrsrc  = 1'b1;
      MEMWB: begin
        o_resultsrc = RES_DATA;
        o_regw      = 1'b1;
      end
      MEMWR: begin
        o_adrsrc = 1'b1;
        o_memw   = 1'b1;
      end
      EXECUTER: o_aluop = 1'b1;
      EXECUTEI: begin
        o_alusrcb = SRCB_IMM;
        o_aluop   = 1'b1;
      end
      ALUWB:    o_regw = 1'b1;
      BRANCH: begin
        o_alusrcb   = SRCB_IMM;
        o_resultsrc = RES_ALU;
        o_branch    = 1'b1;
      end
      UNKNOWN:  o_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/arm_mc_mainfsm.sv
// Multicycle ARM main control FSM with memory-ready stalls.
// Optional retired-instruction counter enabled by ARM_MC_INSTR_COUNT_EN.
module arm_mc_mainfsm
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = ST_W
`ifdef ARM_MC_INSTR_COUNT_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       illegal
`ifdef ARM_MC_INSTR_COUNT_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  statetype_t r_state;
  logic [STATE_W-1:0] w_dec_state;
  logic w_irwrite, w_nextpc, w_regw, w_memw, w_branch, w_illegal;
  logic w_unused_funct;

  assign w_unused_funct = ^Funct[4:1];

  // Decoding FETCH during reset makes the mux selects show fetch values.
  assign w_dec_state = reset ? FETCH : r_state;

  arm_mc_outdec #(
    .STATE_W(STATE_W)
  ) u_outdec (
    .i_state    (w_dec_state),
    .o_irwrite  (w_irwrite),
    .o_adrsrc   (AdrSrc),
    .o_alusrca  (ALUSrcA),
    .o_alusrcb  (ALUSrcB),
    .o_resultsrc(ResultSrc),
    .o_aluop    (ALUOp),
    .o_nextpc   (w_nextpc),
    .o_regw     (w_regw),
    .o_memw     (w_memw),
    .o_branch   (w_branch),
    .o_illegal  (w_illegal)
  );

  assign IRWrite = w_irwrite & mem_ready & ~reset;
  assign NextPC  = w_nextpc & mem_ready & ~reset;
  assign RegW    = w_regw & ~reset;
  assign MemW    = w_memw & ~reset;
  assign Branch  = w_branch & ~reset;
  assign illegal = w_illegal & ~reset;

`ifdef ARM_MC_INSTR_COUNT_EN
  logic [CNT_W-1:0] r_instr_count;
  logic w_retire;

  assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BRANCH) ||
                    ((r_state == MEMWR) && mem_ready);
  assign instr_count = r_instr_count;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
`ifdef ARM_MC_INSTR_COUNT_EN
      r_instr_count <= '0;
`endif
    end else begin
`ifdef ARM_MC_INSTR_COUNT_EN
      if (w_retire) r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
      case (r_state)
        FETCH:    if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (Op)
            OP_MEM:  r_state <= MEMADR;
            OP_DP:   r_state <= Funct[5] ? EXECUTEI : EXECUTER;
            OP_BR:   r_state <= BRANCH;
            default: r_state <= UNKNOWN;
          endcase
        end
        MEMADR:   r_state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:    if (mem_ready) r_state <= MEMWB;
        MEMWB:    r_state <= FETCH;
        MEMWR:    if (mem_ready) r_state <= FETCH;
        EXECUTER: r_state <= ALUWB;
        EXECUTEI: r_state <= ALUWB;
        ALUWB:    r_state <= FETCH;
        BRANCH:   r_state <= FETCH;
        UNKNOWN:  r_state <= FETCH;
        default:  r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mc_mainfsm.sv
// Directed self-checking bench for arm_mc_mainfsm; control outputs are compared per cycle
// against hand-derived control words.
module tb_arm_mc_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch, illegal;
  logic [1:0] ALUSrcB, ResultSrc;
`ifdef ARM_MC_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arm_mc_mainfsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUOp      (ALUOp),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .Branch     (Branch),
    .illegal    (illegal)
`ifdef ARM_MC_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, illegal}
  logic [12:0] w_ctl;
  assign w_ctl = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW,
                  Branch, illegal};

  localparam logic [12:0] C_FETCH = 13'b1_0_1_10_10_0_1_0_0_0_0;
  localparam logic [12:0] C_FSTL  = 13'b0_0_1_10_10_0_0_0_0_0_0;
  localparam logic [12:0] C_DEC   = 13'b0_0_1_10_10_0_0_0_0_0_0;
  localparam logic [12:0] C_MADR  = 13'b0_0_0_01_00_0_0_0_0_0_0;
  localparam logic [12:0] C_MRD   = 13'b0_1_0_00_00_0_0_0_0_0_0;
  localparam logic [12:0] C_MWB   = 13'b0_0_0_00_01_0_0_1_0_0_0;
  localparam logic [12:0] C_MWR   = 13'b0_1_0_00_00_0_0_0_1_0_0;
  localparam logic [12:0] C_EXR   = 13'b0_0_0_00_00_1_0_0_0_0_0;
  localparam logic [12:0] C_EXI   = 13'b0_0_0_01_00_1_0_0_0_0_0;
  localparam logic [12:0] C_AWB   = 13'b0_0_0_00_00_0_0_1_0_0_0;
  localparam logic [12:0] C_BR    = 13'b0_0_0_01_10_0_0_0_0_1_0;
  localparam logic [12:0] C_UNK   = 13'b0_0_0_00_00_0_0_0_0_0_1;
  localparam logic [12:0] C_RST   = 13'b0_0_1_10_10_0_0_0_0_0_0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Op = 2'b11; Funct = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (w_ctl !== C_RST) begin
        failures++;
        $display("FAIL reset cyc%0d ctl=%b exp=%b", i, w_ctl, C_RST);
      end
      step();
    end
    reset = 1'b0;
  endtask

  task automatic test_dp();
    logic [12:0] e [8];
    logic [7:0]  r;
    Op = 2'b00; Funct = 6'b000000;
    e = '{C_FETCH, C_DEC, C_EXR, C_AWB, '0, '0, '0, '0};
    r = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (w_ctl !== e[i]) begin
        failures++;
        $display("FAIL dp cyc%0d ctl=%b exp=%b", i, w_ctl, e[i]);
      end
      step();
    end
  endtask

  task automatic test_load_stall();
    logic [12:0] e [8];
    logic [7:0]  r;
    Op = 2'b01; Funct = 6'b000001;
    e = '{C_FSTL, C_FSTL, C_FETCH, C_DEC, C_MADR, C_MRD, C_MRD, C_MWB};
    r = 8'b0101_0100;  // mem_ready low in DECODE and MEMWB must be ignored
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (w_ctl !== e[i]) begin
        failures++;
        $display("FAIL load cyc%0d ctl=%b exp=%b", i, w_ctl, e[i]);
      end
      step();
    end
  endtask

  task automatic test_store();
    logic [12:0] e [8];
    logic [7:0]  r;
    Op = 2'b01; Funct = 6'b000000;
    e = '{C_FETCH, C_DEC, C_MADR, C_MWR, C_FETCH, C_DEC, C_MADR, C_MWR};
    r = 8'b0111_1111;  // second store stalls one cycle in MEMWR
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (w_ctl !== e[i]) begin
        failures++;
        $display("FAIL store cyc%0d ctl=%b exp=%b", i, w_ctl, e[i]);
      end
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (w_ctl !== C_MWR) begin
      failures++;
      $display("FAIL store_stall ctl=%b exp=%b", w_ctl, C_MWR);
    end
    step();
  endtask

  task automatic test_exec_imm();
    logic [12:0] e [8];
    logic [7:0]  r;
    Op = 2'b00; Funct = 6'b100000;
    e = '{C_FETCH, C_DEC, C_EXI, C_AWB, '0, '0, '0, '0};
    r = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (w_ctl !== e[i]) begin
        failures++;
        $display("FAIL exec_imm cyc%0d ctl=%b exp=%b", i, w_ctl, e[i]);
      end
      step();
    end
  endtask

  task automatic test_branch_illegal();
    logic [12:0] e [8];
    logic [7:0]  r;
    e = '{C_FETCH, C_DEC, C_BR, C_FETCH, C_DEC, C_UNK, C_FETCH, '0};
    r = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      Op = (i < 3) ? 2'b10 : 2'b11;
      mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (w_ctl !== e[i]) begin
        failures++;
        $display("FAIL br_ill cyc%0d ctl=%b exp=%b", i, w_ctl, e[i]);
      end
      if (i < 6) step();
    end
    // Leave the FSM in FETCH: hold it there with mem_ready low across the edge.
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_midstall();
    logic [12:0] e [8];
    logic [7:0]  r;
    Op = 2'b01; Funct = 6'b000001;
    e = '{C_FETCH, C_DEC, C_MADR, C_MRD, '0, '0, '0, '0};
    r = 8'b0000_0111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (w_ctl !== e[i]) begin
        failures++;
        $display("FAIL rst_mid cyc%0d ctl=%b exp=%b", i, w_ctl, e[i]);
      end
      step();
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_ready = (i == 1);
      @(negedge clk);
      checks++;
      if (w_ctl !== C_RST) begin
        failures++;
        $display("FAIL rst_mid_hold cyc%0d ctl=%b exp=%b", i, w_ctl, C_RST);
      end
      step();
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (w_ctl !== C_FSTL) begin
      failures++;
      $display("FAIL rst_mid_after ctl=%b exp=%b", w_ctl, C_FSTL);
    end
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (w_ctl !== C_FETCH) begin
      failures++;
      $display("FAIL rst_mid_fetch ctl=%b exp=%b", w_ctl, C_FETCH);
    end
    step();
  endtask

`ifdef ARM_MC_INSTR_COUNT_EN
  task automatic test_count();
    reset = 1'b1; mem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (instr_count !== 32'd0) begin
      failures++;
      $display("FAIL count_reset got=%0d exp=0", instr_count);
    end
    reset = 1'b0;
    step();
    Op = 2'b00; Funct = 6'b000000;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (instr_count !== 32'd3) begin
      failures++;
      $display("FAIL count_dp got=%0d exp=3", instr_count);
    end
    Op = 2'b01; Funct = 6'b000001;
    for (int i = 0; i < 5; i++) step();
    Op = 2'b11;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (instr_count !== 32'd4) begin
      failures++;
      $display("FAIL count_total got=%0d exp=4", instr_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dp();
    test_load_stall();
    test_store();
    test_exec_imm();
    test_branch_illegal();
    test_dp();
    test_reset_midstall();
`ifdef ARM_MC_INSTR_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
